// File: rtl/ppu_pkg.sv
// Shared PPU definitions: VRAM port states, register indices, palette base and
// address increments.
package ppu_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PEND    = 2'd1,
      ACCESS  = 2'd2,
      CAPTURE = 2'd3
   } vram_port_state_t;

   localparam logic [2:0] REG_STATUS = 3'd2;
   localparam logic [2:0] REG_ADDR   = 3'd6;
   localparam logic [2:0] REG_DATA   = 3'd7;

   localparam int ADDR_W = 14;
   localparam logic [ADDR_W-1:0] PAL_BASE    = 14'h3F00;
   localparam logic [ADDR_W-1:0] PAL_RD_MASK = 14'h2FFF;
   localparam logic [ADDR_W-1:0] INC_1       = 14'd1;
   localparam logic [ADDR_W-1:0] INC_32      = 14'd32;

endpackage

// File: rtl/ppu_pal_mirror.sv
// Palette address remap; with PPU_PAL_MIRROR_EN defined, sprite backdrop entries
// $3F10/14/18/1C fold onto $3F00/04/08/0C, otherwise addresses pass through.
module ppu_pal_mirror
   import ppu_pkg::*;
(
   input  logic [ADDR_W-1:0] addr,
   output logic [ADDR_W-1:0] mapped
);

`ifdef PPU_PAL_MIRROR_EN
   always_comb begin
      mapped = addr;
      if (addr >= PAL_BASE && addr[4] && addr[1:0] == 2'b00)
         mapped[4] = 1'b0;
   end
`else
   assign mapped = addr;
`endif

endmodule

// File: rtl/ppu_vram_port.sv
// CPU-side PPUADDR/PPUDATA access into VRAM with a delayed read buffer and
// busy/own arbitration against the renderer. Optional macro: PPU_PAL_MIRROR_EN.
//
// state   | meaning
// IDLE    | no op outstanding; a $2007 access may be accepted
// PEND    | op latched, waiting for render_busy to drop
// ACCESS  | driving VRAM address and write data / read strobe
// CAPTURE | loading read_buf from VRAM_data_in
module ppu_vram_port
   import ppu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_sel,
   input  logic [2:0]  cpu_addr,
   input  logic        cpu_rw,
   input  logic [7:0]  cpu_data_in,
   output logic [7:0]  cpu_data_out,
   input  logic        ctrl_inc32,
   input  logic        render_busy,
   output logic        cpu_owns_bus,
   output logic [15:0] VRAM_addr,
   output logic [7:0]  VRAM_data_out,
   input  logic [7:0]  VRAM_data_in,
   output logic        VRAM_we,
   output logic        VRAM_re,
   output logic [4:0]  pal_addr,
   input  logic [7:0]  pal_data_in,
   output logic        drop_pulse
);

   localparam logic [1:0] ST_IDLE    = IDLE;
   localparam logic [1:0] ST_PEND    = PEND;
   localparam logic [1:0] ST_ACCESS  = ACCESS;
   localparam logic [1:0] ST_CAPTURE = CAPTURE;

   logic [1:0]        state;
   logic              w;
   logic [5:0]        t_hi;
   logic [ADDR_W-1:0] v;
   logic [7:0]        read_buf;
   logic [ADDR_W-1:0] op_addr;
   logic [7:0]        op_data;
   logic              op_is_rd;

   logic [ADDR_W-1:0] v_map;
   logic [ADDR_W-1:0] op_map;
   logic              sel_status;
   logic              sel_addr;
   logic              sel_data;
   logic              is_pal;
   logic              in_access;

   ppu_pal_mirror u_pal_mirror_v  (.addr(v),       .mapped(v_map));
   ppu_pal_mirror u_pal_mirror_op (.addr(op_addr), .mapped(op_map));

   assign sel_status = cpu_sel && cpu_addr == REG_STATUS && cpu_rw;
   assign sel_addr   = cpu_sel && cpu_addr == REG_ADDR && !cpu_rw;
   assign sel_data   = cpu_sel && cpu_addr == REG_DATA;
   // mirroring only clears bit 4 above PAL_BASE, so it never crosses the base
   assign is_pal     = v_map >= PAL_BASE;
   assign pal_addr   = v_map[4:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         w            <= 1'b0;
         t_hi         <= '0;
         v            <= '0;
         read_buf     <= '0;
         op_addr      <= '0;
         op_data      <= '0;
         op_is_rd     <= 1'b0;
         cpu_data_out <= '0;
         drop_pulse   <= 1'b0;
      end else begin
         drop_pulse <= sel_data && state != ST_IDLE;

         if (sel_status) begin
            w <= 1'b0;
         end else if (sel_addr) begin
            if (!w) begin
               t_hi <= cpu_data_in[5:0];
               w    <= 1'b1;
            end else begin
               v <= {t_hi, cpu_data_in};
               w <= 1'b0;
            end
         end

         if (sel_data && state == ST_IDLE) begin
            // palette reads refill the buffer from the nametable underneath
            op_addr  <= (cpu_rw && is_pal) ? (v & PAL_RD_MASK) : v;
            op_data  <= cpu_data_in;
            op_is_rd <= cpu_rw;
            v        <= v + (ctrl_inc32 ? INC_32 : INC_1);
            if (cpu_rw)
               cpu_data_out <= is_pal ? pal_data_in : read_buf;
         end

         case (state)
            ST_IDLE:    if (sel_data) state <= ST_PEND;
            ST_PEND:    if (!render_busy) state <= ST_ACCESS;
            ST_ACCESS:  state <= op_is_rd ? ST_CAPTURE : ST_IDLE;
            ST_CAPTURE: begin
               read_buf <= VRAM_data_in;
               state    <= ST_IDLE;
            end
            default:    state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      in_access     = state == ST_ACCESS;
      cpu_owns_bus  = in_access || state == ST_CAPTURE;
      VRAM_addr     = in_access ? {2'b00, op_map} : 16'h0000;
      VRAM_data_out = (in_access && !op_is_rd) ? op_data : 8'h00;
      VRAM_we       = in_access && !op_is_rd;
      VRAM_re       = in_access && op_is_rd;
   end

endmodule

// File: tb/tb_ppu_vram_port.sv
// Bench for ppu_vram_port: transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_ppu_vram_port;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_sel;
   logic [2:0]  cpu_addr;
   logic        cpu_rw;
   logic [7:0]  cpu_data_in;
   logic [7:0]  cpu_data_out;
   logic        ctrl_inc32;
   logic        render_busy;
   logic        cpu_owns_bus;
   logic [15:0] VRAM_addr;
   logic [7:0]  VRAM_data_out;
   logic [7:0]  vram_data_in;
   logic        VRAM_we;
   logic        VRAM_re;
   logic [4:0]  pal_addr;
   logic [7:0]  pal_data_in;
   logic        drop_pulse;

   ppu_vram_port dut (
      .clk(clk), .reset(reset), .cpu_sel(cpu_sel), .cpu_addr(cpu_addr),
      .cpu_rw(cpu_rw), .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out),
      .ctrl_inc32(ctrl_inc32), .render_busy(render_busy),
      .cpu_owns_bus(cpu_owns_bus), .VRAM_addr(VRAM_addr),
      .VRAM_data_out(VRAM_data_out), .VRAM_data_in(vram_data_in),
      .VRAM_we(VRAM_we), .VRAM_re(VRAM_re), .pal_addr(pal_addr),
      .pal_data_in(pal_data_in), .drop_pulse(drop_pulse)
   );

   always #5 clk = ~clk;

   logic [7:0] vmem [0:16383];
   logic [7:0] mmem [0:16383];
   logic [7:0] pal_mem [0:31];

   assign pal_data_in = pal_mem[pal_addr];

   always @(posedge clk) begin
      if (VRAM_we) vmem[VRAM_addr[13:0]] = VRAM_data_out;
      if (VRAM_re) vram_data_in <= vmem[VRAM_addr[13:0]];
   end

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [13:0] mir(input logic [13:0] a);
      logic [13:0] r = a;
`ifdef PPU_PAL_MIRROR_EN
      if (a >= 14'h3F00 && (a[4:0] == 5'h10 || a[4:0] == 5'h14 ||
                            a[4:0] == 5'h18 || a[4:0] == 5'h1C))
         r = a - 14'h0010;
`endif
      return r;
   endfunction

   // Reference model: one outstanding op, with its bus cycle timestamped
   int          cyc = 0;
   int          m_v, m_acc, c;
   bit          m_w, m_op_v, m_op_rd, m_drop, busy_at, is_p;
   logic [5:0]  m_thi;
   logic [7:0]  m_buf, m_dout, m_op_d;
   logic [13:0] m_op_a, mv;

   always @(posedge clk) begin
      c = cyc;
      busy_at = m_op_v;
      if (m_op_v && m_acc < 0 && !render_busy) m_acc = c + 1;
      if (m_op_v && !m_op_rd && m_acc == c) begin
         mmem[mir(m_op_a)] = m_op_d;
         m_op_v = 1'b0;
      end
      if (reset) begin
         m_v = 0; m_w = 0; m_thi = '0; m_buf = '0; m_dout = '0; m_drop = 0;
         m_op_v = 0; m_op_rd = 0; m_op_a = '0; m_op_d = '0; m_acc = -1;
      end else begin
         if (m_op_v && m_op_rd && m_acc >= 0 && c == m_acc + 1) begin
            m_buf = mmem[mir(m_op_a)];
            m_op_v = 1'b0;
         end
         m_drop = 1'b0;
         if (cpu_sel) begin
            if (cpu_addr == 3'd2 && cpu_rw) m_w = 1'b0;
            else if (cpu_addr == 3'd6 && !cpu_rw) begin
               if (!m_w) begin m_thi = cpu_data_in[5:0]; m_w = 1'b1; end
               else begin m_v = int'({m_thi, cpu_data_in}); m_w = 1'b0; end
            end else if (cpu_addr == 3'd7) begin
               if (busy_at) m_drop = 1'b1;
               else begin
                  is_p = m_v >= 'h3F00;
                  m_op_a = (cpu_rw && is_p) ? (14'(m_v) & 14'h2FFF) : 14'(m_v);
                  m_op_d = cpu_data_in;
                  m_op_rd = cpu_rw;
                  if (cpu_rw) begin
                     mv = mir(14'(m_v));
                     m_dout = is_p ? pal_mem[mv[4:0]] : m_buf;
                  end
                  m_v = (m_v + (ctrl_inc32 ? 32 : 1)) & 'h3FFF;
                  m_op_v = 1'b1;
                  m_acc = -1;
               end
            end
         end
      end
      cyc = c + 1;
   end

   // Event log for literal expectations
   int          we_count = 0, re_count = 0, drop_count = 0;
   int          last_we_cyc, last_re_cyc, last_drop_cyc;
   logic [15:0] last_we_addr, last_re_addr;
   logic [7:0]  last_we_data;
   bit          e_acc, e_own;
   logic [13:0] e_pv;

   always @(negedge clk) begin
      if (VRAM_we === 1'b1) begin
         we_count++; last_we_cyc = cyc; last_we_addr = VRAM_addr; last_we_data = VRAM_data_out;
      end
      if (VRAM_re === 1'b1) begin
         re_count++; last_re_cyc = cyc; last_re_addr = VRAM_addr;
      end
      if (drop_pulse === 1'b1) begin
         drop_count++; last_drop_cyc = cyc;
      end
      if (chk_en) begin
         e_acc = m_op_v && m_acc == cyc;
         e_own = m_op_v && m_acc >= 0 && cyc >= m_acc;
         e_pv  = mir(14'(m_v));
         chk("cpu_owns_bus", 16'(cpu_owns_bus), 16'(e_own));
         chk("VRAM_we", 16'(VRAM_we), 16'(e_acc && !m_op_rd));
         chk("VRAM_re", 16'(VRAM_re), 16'(e_acc && m_op_rd));
         chk("VRAM_addr", VRAM_addr, e_acc ? {2'b00, mir(m_op_a)} : 16'h0);
         chk("VRAM_data_out", 16'(VRAM_data_out), (e_acc && !m_op_rd) ? 16'(m_op_d) : 16'h0);
         chk("cpu_data_out", 16'(cpu_data_out), 16'(m_dout));
         chk("drop_pulse", 16'(drop_pulse), 16'(m_drop));
         chk("pal_addr", 16'(pal_addr), 16'(e_pv[4:0]));
      end
   end

   task automatic acc(input logic [2:0] a, input logic rw, input logic [7:0] d, output int t);
      @(negedge clk);
      cpu_sel = 1'b1; cpu_addr = a; cpu_rw = rw; cpu_data_in = d; t = cyc;
      @(negedge clk);
      cpu_sel = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic put(input logic [13:0] a, input logic [7:0] d);
      vmem[a] = d; mmem[a] = d;
   endtask

   int t, we0, dr0;
   logic [7:0] rv;

   initial begin
      for (int i = 0; i < 16384; i++) begin
         rv = 8'($urandom);
         vmem[i] = rv; mmem[i] = rv;
      end
      for (int i = 0; i < 32; i++) pal_mem[i] = 8'($urandom);
      pal_mem[5] = 8'h16;
      put(14'h2400, 8'hAA); put(14'h2420, 8'hBB); put(14'h2F05, 8'h5C);
      vram_data_in = 8'h00;
      reset = 1'b1; cpu_sel = 0; cpu_addr = 0; cpu_rw = 0; cpu_data_in = 0;
      ctrl_inc32 = 0; render_busy = 0;
      idle(2);
      chk_en = 1'b1;
      reset = 1'b0;
      chk("rst_cpu_data_out", 16'(cpu_data_out), 16'h0);
      chk("rst_owns", 16'(cpu_owns_bus), 16'h0);
      chk("rst_pal_addr", 16'(pal_addr), 16'h0);

      // address load and write
      acc(3'd6, 0, 8'h21, t); acc(3'd6, 0, 8'h08, t);
      we0 = we_count;
      acc(3'd7, 0, 8'h5A, t); idle(5);
      chk("wr_count", 16'(we_count - we0), 16'd1);
      chk("wr_latency", 16'(last_we_cyc - t), 16'd2);
      chk("wr_addr", last_we_addr, 16'h2108);
      chk("wr_data", 16'(last_we_data), 16'h5A);
      acc(3'd7, 0, 8'h77, t); idle(5);
      chk("wr_inc_addr", last_we_addr, 16'h2109);

      // buffered read with +32
      acc(3'd6, 0, 8'h24, t); acc(3'd6, 0, 8'h00, t);
      ctrl_inc32 = 1;
      acc(3'd7, 1, 8'h00, t); idle(5);
      chk("rd1_old_buf", 16'(cpu_data_out), 16'h00);
      chk("rd1_re_latency", 16'(last_re_cyc - t), 16'd2);
      acc(3'd7, 1, 8'h00, t); idle(5);
      chk("rd2_data", 16'(cpu_data_out), 16'hAA);
      chk("rd2_addr", last_re_addr, 16'h2420);
      acc(3'd7, 0, 8'h33, t); idle(5);
      chk("rd_inc32_v", last_we_addr, 16'h2440);

      // palette read
      ctrl_inc32 = 0;
      acc(3'd6, 0, 8'h3F, t); acc(3'd6, 0, 8'h05, t);
      acc(3'd7, 1, 8'h00, t); idle(5);
      chk("pal_rd_data", 16'(cpu_data_out), 16'h16);
      chk("pal_rd_addr", last_re_addr, 16'h2F05);
      acc(3'd6, 0, 8'h20, t); acc(3'd6, 0, 8'h00, t);
      acc(3'd7, 1, 8'h00, t); idle(5);
      chk("pal_buf_fill", 16'(cpu_data_out), 16'h5C);

      // arbitration and drop
      acc(3'd6, 0, 8'h20, t); acc(3'd6, 0, 8'h00, t);
      render_busy = 1;
      we0 = we_count; dr0 = drop_count;
      acc(3'd7, 0, 8'h99, t); idle(8);
      acc(3'd7, 0, 8'h11, t); idle(10);
      chk("busy_no_we", 16'(we_count - we0), 16'd0);
      chk("drop_count", 16'(drop_count - dr0), 16'd1);
      chk("drop_latency", 16'(last_drop_cyc - t), 16'd1);
      render_busy = 0; idle(6);
      chk("busy_one_we", 16'(we_count - we0), 16'd1);
      chk("busy_we_addr", last_we_addr, 16'h2000);
      chk("busy_we_data", 16'(last_we_data), 16'h99);
      acc(3'd7, 0, 8'h12, t); idle(5);
      chk("drop_v_unchanged", last_we_addr, 16'h2001);

      // latch reset via status read, and wrap
      acc(3'd6, 0, 8'h3F, t); acc(3'd2, 1, 8'h00, t);
      acc(3'd6, 0, 8'h12, t); acc(3'd6, 0, 8'h34, t);
      acc(3'd7, 0, 8'h42, t); idle(5);
      chk("latch_clr_addr", last_we_addr, 16'h1234);
      acc(3'd6, 0, 8'h3F, t); acc(3'd6, 0, 8'hFF, t);
      acc(3'd7, 0, 8'h10, t); idle(5);
      chk("wrap_pre", last_we_addr, 16'h3FFF);
      acc(3'd7, 0, 8'h20, t); idle(5);
      chk("wrap_post", last_we_addr, 16'h0000);

      // palette mirror
      acc(3'd6, 0, 8'h3F, t); acc(3'd6, 0, 8'h10, t);
      acc(3'd7, 0, 8'h55, t); idle(5);
`ifdef PPU_PAL_MIRROR_EN
      chk("mirror_addr", last_we_addr, 16'h3F00);
`else
      chk("mirror_addr", last_we_addr, 16'h3F10);
`endif

      // reset abandons a pending op
      render_busy = 1; we0 = we_count;
      acc(3'd7, 0, 8'h66, t);
      reset = 1; idle(1); reset = 0; render_busy = 0; idle(6);
      chk("reset_abandon", 16'(we_count - we0), 16'd0);

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         cpu_sel = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 4))
            0: cpu_addr = 3'd2;
            1: cpu_addr = 3'd6;
            2, 3: cpu_addr = 3'd7;
            default: cpu_addr = 3'($urandom);
         endcase
         cpu_rw = 1'($urandom);
         cpu_data_in = 8'($urandom);
         ctrl_inc32 = 1'($urandom);
         if ($urandom_range(0, 5) == 0) render_busy = ~render_busy;
         reset = ($urandom_range(0, 399) == 0);
      end
      @(negedge clk);
      cpu_sel = 0; reset = 0; render_busy = 0;
      idle(6);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
